// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, ALU op codes, mux encodings and FSM states for the multicycle MIPS control
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b011;
    localparam logic [2:0] ALUOP_AND   = 3'b100;
    localparam logic [2:0] ALUOP_LUI   = 3'b101;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_R_EXEC,
        S_R_WB,
        S_I_EXEC,
        S_I_WB,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_BRANCH,
        S_JUMP,
        S_ILLEGAL,
        S_ERROR
    } state_t;

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control bundle between the FSM and the datapath (MULTICYCLE_CTRL_PERF_EN adds perf counters)
interface multicycle_control_if
`ifdef MULTICYCLE_CTRL_PERF_EN
    #(parameter int PERF_W = 32)
`endif
    ;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic       reg_write;
    logic       reg_dst;
    logic       illegal_op;
    logic       bus_error;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [PERF_W-1:0] instr_retired;
    logic [PERF_W-1:0] cycle_count;
`endif

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, pc_source, alu_op, alu_src_a, alu_src_b,
               ext_zero, reg_write, reg_dst, illegal_op, bus_error
`ifdef MULTICYCLE_CTRL_PERF_EN
        , output instr_retired, cycle_count
`endif
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, pc_source, alu_op, alu_src_a, alu_src_b,
               ext_zero, reg_write, reg_dst, illegal_op, bus_error
`ifdef MULTICYCLE_CTRL_PERF_EN
        , input instr_retired, cycle_count
`endif
    );

endinterface

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - watchdog counting cycles a memory state waits for mem_ready
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    input  logic mem_ready,
    output logic timeout
);
    // The counter only has to reach WAIT_LIMIT-1: timeout fires in the WAIT_LIMIT-th waiting cycle
    localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive stalled cycles; a completed access or any non-memory state clears the count
    always_comb begin
        cnt_d = '0;
        if (waiting && !mem_ready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Wait counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // mem_ready in the limit cycle suppresses the timeout
    generate
        if (WAIT_LIMIT == 0) begin : g_no_limit
            assign timeout = 1'b0;
        end else begin : g_limit
            assign timeout = waiting && !mem_ready && (cnt_q == CNT_W'(WAIT_LIMIT - 1));
        end
    endgenerate

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for a multicycle MIPS core (MULTICYCLE_CTRL_PERF_EN adds perf counters)
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input logic                  clk,
    input logic                  reset,
    multicycle_control_if.master ctl
);
    state_t state_q, state_d;
    logic   waiting;
    logic   timeout;

    assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);

    mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
        .clk       (clk),
        .rst_n     (reset),
        .waiting   (waiting),
        .mem_ready (ctl.mem_ready),
        .timeout   (timeout)
    );

    // State register; reset forces S_RESET so every strobe drops immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath controls; only ir_write/pc_write in FETCH depend on mem_ready
    always_comb begin
        state_d           = state_q;
        ctl.pc_write      = 1'b0;
        ctl.pc_write_cond = 1'b0;
        ctl.branch_ne     = 1'b0;
        ctl.i_or_d        = 1'b0;
        ctl.mem_read      = 1'b0;
        ctl.mem_write     = 1'b0;
        ctl.ir_write      = 1'b0;
        ctl.mem_to_reg    = 1'b0;
        ctl.pc_source     = PCSRC_ALU;
        ctl.alu_op        = ALUOP_ADD;
        ctl.alu_src_a     = 1'b0;
        ctl.alu_src_b     = SRCB_RT;
        ctl.ext_zero      = 1'b0;
        ctl.reg_write     = 1'b0;
        ctl.reg_dst       = 1'b0;
        ctl.illegal_op    = 1'b0;
        ctl.bus_error     = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
                if (ctl.mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    state_d      = S_DECODE;
                end else if (timeout) begin
                    state_d = S_ERROR;
                end
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                ctl.alu_src_b = SRCB_IMM_SH2;
                case (ctl.opcode)
                    OP_RTYPE:                         state_d = S_R_EXEC;
                    OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
                    OP_J:                             state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_I_EXEC;
                    default:                          state_d = S_ILLEGAL;
                endcase
            end
            S_R_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = ALUOP_RTYPE;
                state_d       = S_R_WB;
            end
            S_R_WB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
                state_d       = S_FETCH;
            end
            S_I_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                case (ctl.opcode)
                    OP_ANDI: begin
                        ctl.alu_op   = ALUOP_AND;
                        ctl.ext_zero = 1'b1;
                    end
                    OP_ORI: begin
                        ctl.alu_op   = ALUOP_OR;
                        ctl.ext_zero = 1'b1;
                    end
                    OP_LUI:  ctl.alu_op = ALUOP_LUI;
                    default: ctl.alu_op = ALUOP_ADD;
                endcase
                state_d = S_I_WB;
            end
            S_I_WB: begin
                ctl.reg_write = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                state_d       = (ctl.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
                if (ctl.mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout) begin
                    state_d = S_ERROR;
                end
            end
            S_MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_WRITE: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
                if (ctl.mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d = S_ERROR;
                end
            end
            S_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_op        = ALUOP_SUB;
                ctl.pc_source     = PCSRC_ALUOUT;
                ctl.pc_write_cond = 1'b1;
                ctl.branch_ne     = (ctl.opcode == OP_BNE);
                state_d           = S_FETCH;
            end
            S_JUMP: begin
                ctl.pc_source = PCSRC_JUMP;
                ctl.pc_write  = 1'b1;
                state_d       = S_FETCH;
            end
            // PC was already incremented in FETCH, so the bad instruction is simply skipped
            S_ILLEGAL: begin
                ctl.illegal_op = 1'b1;
                state_d        = S_FETCH;
            end
            // Only reset leaves ERROR, which makes bus_error sticky
            S_ERROR: ctl.bus_error = 1'b1;
            default: state_d = S_ERROR;
        endcase
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [PERF_W-1:0] cycle_count_q, cycle_count_d;
    logic [PERF_W-1:0] instr_retired_q, instr_retired_d;
    logic              retire;

    assign retire = (state_d == S_FETCH) &&
                    (state_q inside {S_R_WB, S_I_WB, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP});

    // Free-running activity counters; both wrap naturally
    always_comb begin
        cycle_count_d   = cycle_count_q;
        instr_retired_d = instr_retired_q;
        if ((state_q != S_RESET) && (state_q != S_ERROR)) begin
            cycle_count_d = cycle_count_q + 1'b1;
        end
        if (retire) begin
            instr_retired_d = instr_retired_q + 1'b1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count_q   <= '0;
            instr_retired_q <= '0;
        end else begin
            cycle_count_q   <= cycle_count_d;
            instr_retired_q <= instr_retired_d;
        end
    end

    assign ctl.cycle_count   = cycle_count_q;
    assign ctl.instr_retired = instr_retired_q;
`endif

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM that sequences the shared single ALU, register file, PC and unified instruction/data memory for one multicycle MIPS core.
- Decodes the 6-bit opcode and drives the datapath mux selects and write enables.
- Emits alu_op codes, which the ALU control decoder turns into ALU operations.
- Handles a memory ready handshake with a watchdog timeout.

Parameters:
- WAIT_LIMIT, 15: max cycles a memory state waits for mem_ready before entering ERROR; 0 disables the timeout.
- PERF_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- opcode  in  6  instruction register bits [31:26]
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if branch condition is true
- branch_ne  out  1  condition is ~zero (BNE) instead of zero (BEQ)
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  writeback source: 1 = MDR, 0 = ALUOut
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- alu_op  out  3  000 ADD, 001 SUB, 010 RTYPE (use funct), 011 OR, 100 AND, 101 LUI
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 = rt, 01 = const 4, 10 = immediate, 11 = imm<<2
- ext_zero  out  1  zero-extend immediate (ANDI/ORI)
- reg_write  out  1  register file write
- reg_dst  out  1  1 = rd, 0 = rt
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- bus_error  out  1  sticky until reset

Behaviour:
- Reset (reset=0, asynchronous):
  - state = S_RESET, wait counter = 0, bus_error = 0.
  - All outputs are 0 in S_RESET.
  - S_RESET always goes to FETCH on the next edge.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1 (the only Mealy-qualified outputs).
  - Advances to DECODE on mem_ready.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target into ALUOut). Dispatch on opcode:
  - 000000 R_EXEC
  - 100011/101011 MEM_ADDR
  - 000100/000101 BRANCH
  - 000010 JUMP
  - 001000/001100/001101/001111 I_EXEC
  - anything else ILLEGAL
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=RTYPE. Next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op per opcode (ADDI→ADD, ANDI→AND, ORI→OR, LUI→LUI); ext_zero=1 for ANDI/ORI. Next I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Next MEM_READ (LW) or MEM_WRITE (SW).
- MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Holds until mem_ready, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=01, pc_write_cond=1, branch_ne=(opcode==000101). Next FETCH.
- JUMP: pc_source=10, pc_write=1. Next FETCH.
- ILLEGAL: illegal_op=1 for one cycle. Next FETCH; the PC is already incremented, so the instruction is skipped.
- Wait counter:
  - Cleared on entry to FETCH, MEM_READ or MEM_WRITE; increments each cycle while in one of those states with mem_ready=0.
  - If WAIT_LIMIT≠0 and the counter reaches WAIT_LIMIT with mem_ready still 0, go to ERROR.
  - mem_ready=1 in the limit cycle wins; no error is raised.
- ERROR: all strobes 0, bus_error=1; stays in ERROR until reset.
- opcode is sampled only in DECODE and I_EXEC/MEM_ADDR/BRANCH; it is stable because ir_write=0 outside FETCH.
- Reset asserted mid-access: outputs drop to 0 immediately (asynchronous); no partial write completes beyond that cycle.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- Defined: extra outputs instr_retired[PERF_W-1:0] and cycle_count[PERF_W-1:0].
  - cycle_count increments every cycle outside S_RESET/ERROR.
  - instr_retired increments on each transition into FETCH from a completing state (R_WB, I_WB, MEM_WB, MEM_WRITE, BRANCH, JUMP); not from ILLEGAL.
  - Both counters wrap modulo 2^PERF_W and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI);
  - alu_op codes (ALUOP_ADD … ALUOP_LUI);
  - the state enum;
  - the pc_source and alu_src_b encodings.
- One natural sub-module: mem_wait_timer, holding the wait counter and the timeout compare, with WAIT_LIMIT passed through.

Test Plan:
- Release reset, mem_ready=1 always, opcode=000000 → states S_RESET,FETCH,DECODE,R_EXEC,R_WB; alu_op=010 in R_EXEC; reg_write=1,reg_dst=1 in R_WB; back at FETCH on cycle 5.
- LW (100011), mem_ready low 3 cycles in MEM_READ → mem_read=1,i_or_d=1 held 4 cycles; then MEM_WB with mem_to_reg=1,reg_write=1; bus_error=0.
- BNE (000101) → BRANCH with alu_op=001, pc_write_cond=1, branch_ne=1, pc_source=01; BEQ gives branch_ne=0.
- ORI (001101) → I_EXEC alu_op=011, ext_zero=1, alu_src_b=10; LUI gives alu_op=101, ext_zero=0.
- WAIT_LIMIT=15, mem_ready stuck 0 in FETCH → ERROR after 15 waiting cycles, bus_error=1, strobes 0 until reset; reset clears bus_error and restarts at S_RESET.
- Opcode 111111 → illegal_op pulses one cycle, then FETCH; with MULTICYCLE_CTRL_PERF_EN, instr_retired is unchanged across the illegal instruction.
